i2s_tx_serializer: RTL and testbench

- Parametrised stereo successor to the team's single-word bit shifter.
- Accepts left/right sample pairs over a valid/ready handshake and buffers one pair.
- Serialises each pair onto an I2S-style sd/ws pair, one bit per bit-clock enable pulse.
- Configurable sample width, slot width, bit order and one-bit I2S delay; flags underrun when no pair is ready at a frame boundary.

---
 rtl/i2s_tx_serializer.sv | 160 ++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S-style transmitter: buffers one left/right pair behind a valid/ready
// port and shifts it out on sd/ws, one bit per sclk_en strobe.
module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int MSB_FIRST  = 1,
  parameter int I2S_DELAY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_en,
  // Input handshake: a pair transfers on any clk where in_valid && in_ready.
  // in_ready depends only on registers and rst, never on in_valid.
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  sd,
  output logic                  ws,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_C   = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] SLOT_END = CW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] DW_C     = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] DELAY_C  = CW'(I2S_DELAY);

  if (SLOT_WIDTH < DATA_WIDTH) begin : g_bad_slot
    $error("i2s_tx_serializer: SLOT_WIDTH must be >= DATA_WIDTH");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data
    $error("i2s_tx_serializer: DATA_WIDTH must be >= 1");
  end

  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
  logic [DATA_WIDTH-1:0] frame_left_q, frame_left_d;
  logic [DATA_WIDTH-1:0] frame_right_q, frame_right_d;
  logic                  prev_q, prev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sd_q, sd_d;
  logic                  ws_q, ws_d;
  logic                  fs_q, fs_d;
  logic                  ur_q, ur_d;

  logic                  accept;
  logic                  ws_n;
  logic [CW-1:0]         pos;
  logic [CW-1:0]         didx;
  logic [CW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] chan;
  logic [DATA_WIDTH-1:0] shifted;

  assign in_ready    = !rst && !hold_full_q;
  assign accept      = in_valid && in_ready;
  assign sd          = sd_q;
  assign ws          = ws_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

  always_comb begin
    hold_full_d   = hold_full_q;
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    frame_left_d  = frame_left_q;
    frame_right_d = frame_right_q;
    prev_d        = prev_q;
    cnt_d         = cnt_q;
    sd_d          = sd_q;
    ws_d          = ws_q;
    fs_d          = 1'b0;
    ur_d          = 1'b0;
    ws_n          = 1'b0;
    pos           = '0;
    didx          = '0;
    shamt         = '0;
    chan          = '0;
    shifted       = '0;

    if (accept) begin
      hold_left_d  = in_left;
      hold_right_d = in_right;
      hold_full_d  = 1'b1;
    end

    if (sclk_en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      // Frame load shares the edge with bit 0, so bit 0 comes from the new data.
      if (cnt_q == CNT_LAST) begin
        fs_d = 1'b1;
        if (hold_full_q) begin
          frame_left_d  = hold_left_q;
          frame_right_d = hold_right_q;
          hold_full_d   = 1'b0;
        end else begin
          frame_left_d  = '0;
          frame_right_d = '0;
          ur_d          = 1'b1;
        end
      end

      ws_n = (cnt_d >= SLOT_C);
      pos  = ws_n ? (cnt_d - SLOT_C) : cnt_d;
      chan = ws_n ? frame_right_d : frame_left_d;
      ws_d = ws_n;

      if (I2S_DELAY != 0 && pos == '0) begin
        sd_d = (SLOT_WIDTH > DATA_WIDTH) ? 1'b0 : prev_q;
      end else begin
        didx = pos - DELAY_C;
        if (didx < DW_C) begin
          shamt   = (MSB_FIRST != 0) ? (DW_C - CW'(1) - didx) : didx;
          shifted = chan >> shamt;
          sd_d    = shifted[0];
        end else begin
          sd_d = 1'b0;
        end
      end

      // With a one-bit delay the slot's final data bit spills into the next slot.
      if (pos == SLOT_END) begin
        prev_d = (MSB_FIRST != 0) ? chan[0] : chan[DATA_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q   <= 1'b0;
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      frame_left_q  <= '0;
      frame_right_q <= '0;
      prev_q        <= 1'b0;
      cnt_q         <= CNT_LAST;
      sd_q          <= 1'b0;
      ws_q          <= 1'b0;
      fs_q          <= 1'b0;
      ur_q          <= 1'b0;
    end else begin
      hold_full_q   <= hold_full_d;
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      frame_left_q  <= frame_left_d;
      frame_right_q <= frame_right_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      sd_q          <= sd_d;
      ws_q          <= ws_d;
      fs_q          <= fs_d;
      ur_q          <= ur_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: four configurations share clk/rst/sclk_en,
// each with its own handshake inputs; serial bits are logged per strobe and packed.
module tb_i2s_tx_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sclk_en;
  logic        valid_r [4];
  logic [23:0] left_r  [4];
  logic [23:0] right_r [4];
  logic        rdy_w [4];
  logic        sd_w  [4];
  logic        ws_w  [4];
  logic        fs_w  [4];
  logic        ur_w  [4];

  logic sd_log [4][128];
  logic ws_log [4][128];
  logic fs_log [4][128];
  logic ur_log [4][128];

  int   n_total = 0;
  int   n_bad   = 0;
  int   xfer_cnt;
  logic xfer_clr;

  // u0: 16/16 MSB-first left-justified
  i2s_tx_serializer #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .MSB_FIRST(1), .I2S_DELAY(0)) u0 (
    .clk(clk), .rst(rst), .sclk_en(sclk_en), .in_valid(valid_r[0]), .in_ready(rdy_w[0]),
    .in_left(left_r[0][15:0]), .in_right(right_r[0][15:0]),
    .sd(sd_w[0]), .ws(ws_w[0]), .frame_start(fs_w[0]), .underrun(ur_w[0]));
  // u1: 16/16 MSB-first Philips delay
  i2s_tx_serializer #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .MSB_FIRST(1), .I2S_DELAY(1)) u1 (
    .clk(clk), .rst(rst), .sclk_en(sclk_en), .in_valid(valid_r[1]), .in_ready(rdy_w[1]),
    .in_left(left_r[1][15:0]), .in_right(right_r[1][15:0]),
    .sd(sd_w[1]), .ws(ws_w[1]), .frame_start(fs_w[1]), .underrun(ur_w[1]));
  // u2: 24/32 MSB-first Philips delay
  i2s_tx_serializer #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .MSB_FIRST(1), .I2S_DELAY(1)) u2 (
    .clk(clk), .rst(rst), .sclk_en(sclk_en), .in_valid(valid_r[2]), .in_ready(rdy_w[2]),
    .in_left(left_r[2]), .in_right(right_r[2]),
    .sd(sd_w[2]), .ws(ws_w[2]), .frame_start(fs_w[2]), .underrun(ur_w[2]));
  // u3: 16/16 LSB-first left-justified
  i2s_tx_serializer #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .MSB_FIRST(0), .I2S_DELAY(0)) u3 (
    .clk(clk), .rst(rst), .sclk_en(sclk_en), .in_valid(valid_r[3]), .in_ready(rdy_w[3]),
    .in_left(left_r[3][15:0]), .in_right(right_r[3][15:0]),
    .sd(sd_w[3]), .ws(ws_w[3]), .frame_start(fs_w[3]), .underrun(ur_w[3]));

  always @(posedge clk) begin
    if (xfer_clr) xfer_cnt <= 0;
    else if (valid_r[0] && rdy_w[0]) xfer_cnt <= xfer_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_sd(input int i, input int k0);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 32; j++) w = {w[30:0], sd_log[i][k0+j]};
    return w;
  endfunction

  function automatic logic [31:0] pack_ws(input int i, input int k0);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 32; j++) w = {w[30:0], ws_log[i][k0+j]};
    return w;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    repeat (3) @(negedge clk);
    sclk_en = 1'b1;
    @(negedge clk);
    sclk_en = 1'b0;
  endtask

  task automatic log_step(input int k);
    for (int i = 0; i < 4; i++) begin
      sd_log[i][k] = sd_w[i];
      ws_log[i][k] = ws_w[i];
      fs_log[i][k] = fs_w[i];
      ur_log[i][k] = ur_w[i];
    end
  endtask

  task automatic push(input int i, input logic [23:0] l, input logic [23:0] r);
    valid_r[i] = 1'b1;
    left_r[i]  = l;
    right_r[i] = r;
    @(negedge clk);
    valid_r[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_ur;
    int cnt_fs;
    rst      = 1'b1;
    sclk_en  = 1'b0;
    xfer_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_r[i] = 1'b0;
      left_r[i]  = '0;
      right_r[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_sd%0d", i), {31'd0, sd_w[i]}, 32'd0);
      check_eq($sformatf("rst_ws%0d", i), {31'd0, ws_w[i]}, 32'd0);
      check_eq($sformatf("rst_fs%0d", i), {31'd0, fs_w[i]}, 32'd0);
      check_eq($sformatf("rst_ur%0d", i), {31'd0, ur_w[i]}, 32'd0);
      check_eq($sformatf("rst_rdy%0d", i), {31'd0, rdy_w[i]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("rdy_after_rst", {31'd0, rdy_w[0]}, 32'd1);

    // Phase 1: one pair into every instance before the first wrap
    valid_r[0] = 1'b1; left_r[0] = 24'h00A5F0; right_r[0] = 24'h000F0F;
    valid_r[1] = 1'b1; left_r[1] = 24'h00A5F0; right_r[1] = 24'h000F0F;
    valid_r[2] = 1'b1; left_r[2] = 24'hFFFFFF; right_r[2] = 24'h123456;
    valid_r[3] = 1'b1; left_r[3] = 24'h000001; right_r[3] = 24'h008000;
    @(negedge clk);
    for (int i = 0; i < 4; i++) valid_r[i] = 1'b0;
    for (int i = 0; i < 4; i++) check_eq($sformatf("rdy_full%0d", i), {31'd0, rdy_w[i]}, 32'd0);

    for (int k = 0; k < 96; k++) begin
      step();
      log_step(k);
      if (k == 0) begin
        push(1, 24'h008001, 24'h000001);
        check_eq("fs_one_clk", {31'd0, fs_w[0]}, 32'd0);
      end
      if (k == 40) push(0, 24'h001234, 24'h008421);
    end

    check_eq("u0_f1_sd", pack_sd(0, 0), 32'hA5F0_0F0F);
    check_eq("u0_f1_ws", pack_ws(0, 0), 32'h0000_FFFF);
    check_eq("u0_f1_fs", {31'd0, fs_log[0][0]}, 32'd1);
    check_eq("u0_f1_ur", {31'd0, ur_log[0][0]}, 32'd0);
    check_eq("u0_b1_fs", {31'd0, fs_log[0][1]}, 32'd0);
    check_eq("u0_f2_sd", pack_sd(0, 32), 32'h0000_0000);
    check_eq("u0_f2_fs", {31'd0, fs_log[0][32]}, 32'd1);
    check_eq("u0_f2_ur", {31'd0, ur_log[0][32]}, 32'd1);
    check_eq("u0_f3_sd", pack_sd(0, 64), 32'h1234_8421);
    check_eq("u0_f3_fs", {31'd0, fs_log[0][64]}, 32'd1);
    check_eq("u0_f3_ur", {31'd0, ur_log[0][64]}, 32'd0);
    check_eq("u1_f1_sd", pack_sd(1, 0), 32'h52F8_0787);
    check_eq("u1_f2_sd", pack_sd(1, 32), 32'hC000_8000);
    check_eq("u1_f2_ur", {31'd0, ur_log[1][32]}, 32'd0);
    check_eq("u1_f3_sd", pack_sd(1, 64), 32'h8000_0000);
    check_eq("u2_left", pack_sd(2, 0), 32'h7FFF_FF80);
    check_eq("u2_right", pack_sd(2, 32), 32'h091A_2B00);
    check_eq("u2_ws_l", pack_ws(2, 0), 32'h0000_0000);
    check_eq("u2_ws_r", pack_ws(2, 32), 32'hFFFF_FFFF);
    check_eq("u2_mid_fs", {31'd0, fs_log[2][32]}, 32'd0);
    check_eq("u2_f2_fs", {31'd0, fs_log[2][64]}, 32'd1);
    check_eq("u2_f2_ur", {31'd0, ur_log[2][64]}, 32'd1);
    check_eq("u2_f2_ws", {31'd0, ws_log[2][64]}, 32'd0);
    check_eq("u3_f1_sd", pack_sd(3, 0), 32'h8000_0001);

    // Phase 2: continuous in_valid on u0, then reset mid right slot
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    xfer_clr   = 1'b0;
    valid_r[0] = 1'b1;
    left_r[0]  = 24'h00A5F0;
    right_r[0] = 24'h000F0F;
    for (int k = 0; k < 117; k++) begin
      step();
      log_step(k);
      if (k % 32 == 0) begin
        check_eq($sformatf("bp_rdy_wrap%0d", k), {31'd0, rdy_w[0]}, 32'd1);
        @(negedge clk);
        check_eq($sformatf("bp_rdy_refill%0d", k), {31'd0, rdy_w[0]}, 32'd0);
      end
    end
    check_eq("bp_xfers", xfer_cnt, 32'd5);
    check_eq("bp_f2_sd", pack_sd(0, 32), 32'hA5F0_0F0F);
    check_eq("bp_f3_sd", pack_sd(0, 64), 32'hA5F0_0F0F);
    cnt_ur = 0;
    cnt_fs = 0;
    for (int k = 0; k < 117; k++) begin
      cnt_ur += int'(ur_log[0][k]);
      cnt_fs += int'(fs_log[0][k]);
    end
    check_eq("bp_ur_count", cnt_ur, 32'd0);
    check_eq("bp_fs_count", cnt_fs, 32'd4);
    check_eq("pre_rst_sd", {31'd0, sd_w[0]}, 32'd1);
    check_eq("pre_rst_ws", {31'd0, ws_w[0]}, 32'd1);

    valid_r[0] = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check_eq("midrst_sd", {31'd0, sd_w[0]}, 32'd0);
    check_eq("midrst_ws", {31'd0, ws_w[0]}, 32'd0);
    check_eq("midrst_rdy", {31'd0, rdy_w[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rdy", {31'd0, rdy_w[0]}, 32'd1);
    step();
    check_eq("post_rst_fs", {31'd0, fs_w[0]}, 32'd1);
    check_eq("post_rst_ur", {31'd0, ur_w[0]}, 32'd1);
    check_eq("post_rst_sd", {31'd0, sd_w[0]}, 32'd0);
    check_eq("post_rst_ws", {31'd0, ws_w[0]}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
